conv_core_strip_nch: RTL and testbench
======================================

# conv_core_strip_nch

Parametrised multi-channel strip convolution engine: the next generation of the single-channel 2x2 strip core. It accepts one K-row image strip plus its KxK filter per channel over a valid/ready handshake. It accumulates the per-column dot products across CH channels, one output column per cycle, and presents the OUT_W = IMG_W-K+1 results on a held valid/ready output. It sits between the line-buffer/feature-map fetch and the post-processing (bias/activation) stage.

## Interface
- DATA_W, 8, unsigned pixel/weight width
- K, 2, kernel size (KxK), K >= 1
- IMG_W, 5, strip width in pixels, IMG_W >= K
- CH, 3, input channels accumulated per result, CH >= 1
- ACC_W, 16, width of each output accumulator
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  strip/filter beat valid
- in_ready  out  1  engine can accept a beat
- image  in  DATA_W*K*IMG_W  strip, row-major; element i=r*IMG_W+c at [DATA_W*(K*IMG_W-i)-1 -: DATA_W] (element 0 in MSBs)
- filter  in  DATA_W*K*K  weights, row-major, element 0 in MSBs
- out_valid  out  1  conv_out holds a complete CH-channel result
- out_ready  in  1  downstream accepts result
- conv_out  out  ACC_W*(IMG_W-K+1)  column j at [ACC_W*(OUT_W-j)-1 -: ACC_W] (column 0 in MSBs)
- busy  out  1  high in any state other than IDLE with ch_cnt==0

## Operation
- States: IDLE, CALC, OUT. ch_cnt counts 0..CH; col counts 0..OUT_W-1.
- IDLE: in_ready=1. On in_valid&&in_ready: latch image and filter, ch_cnt+=1, col=0, go CALC.
- CALC: in_ready=0. Each cycle: acc[col] += sum over r<K, c<K of img[r][col+c]*flt[r][c], with K*K multipliers in parallel.
  - col < OUT_W-1: col+=1, stay in CALC.
  - col == OUT_W-1 and ch_cnt < CH: go IDLE to fetch the next channel.
  - col == OUT_W-1 and ch_cnt == CH: go OUT.
- OUT: out_valid=1 and conv_out=acc[], both held stable. On out_ready: clear all acc, set ch_cnt=0, go IDLE.
- Arithmetic: all values unsigned. The per-column partial sum is 2*DATA_W+clog2(K*K) bits, computed without loss. Accumulation into ACC_W wraps modulo 2^ACC_W (see Configuration).
- in_valid outside IDLE is ignored; no beat is latched. out_ready outside OUT is ignored.
- image and filter are sampled only on the accepting edge. Input changes during CALC have no effect.
- Reset (rst_n low at an edge, in any state, including mid-CALC or in OUT): state=IDLE, ch_cnt=0, col=0, all acc=0. Any partial result is discarded.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, conv_out=0, busy=0.
- A beat accepted at edge t puts the engine in CALC for cycles t+1..t+OUT_W. in_ready returns high in cycle t+OUT_W+1.
- With in_valid held high, beats are accepted every OUT_W+1 cycles. out_valid rises CH*(OUT_W+1) cycles after the first accepting edge (15 at the defaults).
- out_valid falls in the cycle after the out_ready handshake edge. in_ready is high in that same cycle. A new beat accepted in that cycle starts from cleared accumulators.
- There is no output bypass. in_ready is 0 throughout OUT.

## Configuration
- CONV_SAT_EN defined: each accumulation clamps to 2^ACC_W-1 if the true sum would exceed it. The clamp is sticky until the accumulators are cleared.
- CONV_SAT_EN undefined: modulo-2^ACC_W wrap, no clamp logic.

## Test plan
All scenarios use the defaults (DATA_W=8, K=2, IMG_W=5, CH=3, ACC_W=16).
- Basic, 3 beats, each image rows {1,2,3,4,1}/{2,3,4,1,2} and filter {1,2}/{1,0} -> conv_out {21,33,45,21}; out_valid in cycle 15 after the first accept.
- Per-channel filters: beat 1 as above, beats 2-3 with filter all 0 -> conv_out {7,11,15,7}.
- Backpressure: out_ready low for 10 cycles in OUT -> conv_out and out_valid stable, in_ready=0. After the handshake, the next 3-beat group yields a fresh (non-accumulated) result.
- Overflow: all pixels and weights 255, 3 beats -> with CONV_SAT_EN every column = 65535; without it every column = 59404.
- Reset at cycle 3 of channel 2's CALC, then a full basic sequence -> outputs 0 during reset, then result {21,33,45,21}.
- in_valid pulsed during CALC -> no beat accepted, ch_cnt unchanged, result unaffected.

Source files
------------

// File: rtl/conv_core_strip_nch.sv
// Multi-channel KxK strip convolution: accumulates CH channel beats, one output column per cycle.
// Define CONV_SAT_EN to clamp accumulators at 2^ACC_W-1 instead of wrapping.
module conv_core_strip_nch #(
  parameter int DATA_W = 8,
  parameter int K      = 2,
  parameter int IMG_W  = 5,
  parameter int CH     = 3,
  parameter int ACC_W  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W*K*IMG_W-1:0]         image,
  input  logic [DATA_W*K*K-1:0]             filter,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ACC_W*(IMG_W-K+1)-1:0]      conv_out,
  output logic                              busy
);

  localparam int OUT_W  = IMG_W - K + 1;
  localparam int PSUM_W = 2 * DATA_W + $clog2(K * K);
  localparam int COL_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int CNT_W  = $clog2(CH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             ch_cnt_q, ch_cnt_d;
  logic [COL_W-1:0]             col_q, col_d;
  logic [DATA_W*K*IMG_W-1:0]    image_q, image_d;
  logic [DATA_W*K*K-1:0]        filter_q, filter_d;
  logic [ACC_W-1:0]             acc_q [OUT_W];
  logic [ACC_W-1:0]             acc_d [OUT_W];

  logic [DATA_W-1:0]            pix [K][IMG_W];
  logic [DATA_W-1:0]            wgt [K][K];
  logic [PSUM_W-1:0]            psum;
  logic [ACC_W-1:0]             acc_upd;

  genvar gi;
  generate
    for (gi = 0; gi < K * IMG_W; gi++) begin : g_pix
      assign pix[gi / IMG_W][gi % IMG_W] = image_q[DATA_W*(K*IMG_W-gi)-1 -: DATA_W];
    end
    for (gi = 0; gi < K * K; gi++) begin : g_wgt
      assign wgt[gi / K][gi % K] = filter_q[DATA_W*(K*K-gi)-1 -: DATA_W];
    end
    for (gi = 0; gi < OUT_W; gi++) begin : g_out
      assign conv_out[ACC_W*(OUT_W-gi)-1 -: ACC_W] = (state_q == S_OUT) ? acc_q[gi] : '0;
    end
  endgenerate

  // Window for the current column: K*K products summed in one cycle, lossless width.
  always_comb begin
    psum = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        psum = psum + PSUM_W'(pix[r][int'(col_q) + c]) * PSUM_W'(wgt[r][c]);
      end
    end
  end

`ifdef CONV_SAT_EN
  localparam int SUM_W = ((ACC_W > PSUM_W) ? ACC_W : PSUM_W) + 1;
  logic [SUM_W-1:0] sum_wide;

  always_comb begin
    sum_wide = SUM_W'(acc_q[col_q]) + SUM_W'(psum);
    if (sum_wide > SUM_W'({ACC_W{1'b1}})) begin
      acc_upd = '1;
    end else begin
      acc_upd = sum_wide[ACC_W-1:0];
    end
  end
`else
  always_comb begin
    acc_upd = acc_q[col_q] + ACC_W'(psum);
  end
`endif

  always_comb begin
    state_d   = state_q;
    ch_cnt_d  = ch_cnt_q;
    col_d     = col_q;
    image_d   = image_q;
    filter_d  = filter_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          image_d  = image;
          filter_d = filter;
          ch_cnt_d = ch_cnt_q + CNT_W'(1);
          col_d    = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d[col_q] = acc_upd;
        if (col_q == COL_W'(OUT_W - 1)) begin
          state_d = (ch_cnt_q == CNT_W'(CH)) ? S_OUT : S_IDLE;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          for (int i = 0; i < OUT_W; i++) begin
            acc_d[i] = '0;
          end
          ch_cnt_d = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ch_cnt_q <= '0;
      col_q    <= '0;
      image_q  <= '0;
      filter_q <= '0;
      for (int i = 0; i < OUT_W; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ch_cnt_q <= ch_cnt_d;
      col_q    <= col_d;
      image_q  <= image_d;
      filter_q <= filter_d;
      acc_q    <= acc_d;
    end
  end

  assign busy = !((state_q == S_IDLE) && (ch_cnt_q == '0));

endmodule

// File: tb/tb_conv_core_strip_nch.sv
// Self-checking bench for conv_core_strip_nch at default parameters.
module tb_conv_core_strip_nch;
  localparam int DATA_W = 8;
  localparam int K      = 2;
  localparam int IMG_W  = 5;
  localparam int CH     = 3;
  localparam int ACC_W  = 16;
  localparam int OUT_W  = IMG_W - K + 1;

  logic                         clk;
  logic                         rst_n;
  logic                         in_valid;
  logic                         in_ready;
  logic [DATA_W*K*IMG_W-1:0]    image;
  logic [DATA_W*K*K-1:0]        filter;
  logic                         out_valid;
  logic                         out_ready;
  logic [ACC_W*OUT_W-1:0]       conv_out;
  logic                         busy;

  conv_core_strip_nch #(
    .DATA_W(DATA_W), .K(K), .IMG_W(IMG_W), .CH(CH), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .image(image), .filter(filter), .out_valid(out_valid), .out_ready(out_ready),
    .conv_out(conv_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;
  longint exp_tot [OUT_W];
  int img_a [K][IMG_W];
  int flt_a [K][K];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W*K*IMG_W-1:0] pack_img();
    logic [DATA_W*K*IMG_W-1:0] v;
    v = '0;
    for (int i = 0; i < K * IMG_W; i++) v[DATA_W*(K*IMG_W-i)-1 -: DATA_W] = img_a[i / IMG_W][i % IMG_W][DATA_W-1:0];
    return v;
  endfunction

  function automatic logic [DATA_W*K*K-1:0] pack_flt();
    logic [DATA_W*K*K-1:0] v;
    v = '0;
    for (int i = 0; i < K * K; i++) v[DATA_W*(K*K-i)-1 -: DATA_W] = flt_a[i / K][i % K][DATA_W-1:0];
    return v;
  endfunction

  // Reference: exact channel-summed dot products, reduced to ACC_W at read-out.
  task automatic model_clear();
    for (int j = 0; j < OUT_W; j++) exp_tot[j] = 0;
  endtask

  task automatic model_add();
    for (int j = 0; j < OUT_W; j++)
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          exp_tot[j] += longint'(img_a[r][j+c]) * longint'(flt_a[r][c]);
  endtask

  function automatic logic [63:0] exp_col(input int j);
    longint lim;
    lim = (longint'(1) << ACC_W);
`ifdef CONV_SAT_EN
    return (exp_tot[j] > lim - 1) ? 64'(lim - 1) : 64'(exp_tot[j]);
`else
    return 64'(exp_tot[j] % lim);
`endif
  endfunction

  function automatic logic [ACC_W-1:0] col_of(input int j);
    return conv_out[ACC_W*(OUT_W-j)-1 -: ACC_W];
  endfunction

  task automatic set_basic(input bit zero_flt);
    int r0 [IMG_W];
    int r1 [IMG_W];
    r0 = '{1, 2, 3, 4, 1};
    r1 = '{2, 3, 4, 1, 2};
    for (int c = 0; c < IMG_W; c++) begin
      img_a[0][c] = r0[c];
      img_a[1][c] = r1[c];
    end
    flt_a[0][0] = zero_flt ? 0 : 1;
    flt_a[0][1] = zero_flt ? 0 : 2;
    flt_a[1][0] = zero_flt ? 0 : 1;
    flt_a[1][1] = 0;
  endtask

  task automatic set_fill(input bit rnd);
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < IMG_W; c++) img_a[r][c] = rnd ? int'($urandom_range(0, 255)) : 255;
      for (int c = 0; c < K; c++) flt_a[r][c] = rnd ? int'($urandom_range(0, 255)) : 255;
    end
  endtask

  task automatic drive_beat(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    image    = pack_img();
    filter   = pack_flt();
    in_valid = 1'b1;
    @(posedge clk);
    model_add();
    @(negedge clk);
    in_valid = 1'b0;
    image    = ~image;
    filter   = ~filter;
  endtask

  task automatic pulse_in_valid(input string tag);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_calc_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_calc_busy"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic check_result(input string tag);
    for (int j = 0; j < OUT_W; j++)
      chk($sformatf("%s_col%0d", tag, j), 64'(col_of(j)), exp_col(j));
    chk({tag, "_out_in_ready"}, 64'(in_ready), 64'd0);
    $display("%s: conv_out={%0d,%0d,%0d,%0d} expected={%0d,%0d,%0d,%0d}", tag,
             col_of(0), col_of(1), col_of(2), col_of(3),
             exp_col(0), exp_col(1), exp_col(2), exp_col(3));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_hs_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_hs_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_hs_busy"}, 64'(busy), 64'd0);
    model_clear();
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_conv_out"}, 64'(conv_out), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    rst_n = 1'b1;
    model_clear();
    $display("%s: reset applied", tag);
  endtask

  task automatic run_group(input string tag, input int mode, input bit pulse);
    for (int b = 0; b < CH; b++) begin
      case (mode)
        0: set_basic(1'b0);
        1: set_basic(b != 0);
        2: set_fill(1'b1);
        default: set_fill(1'b0);
      endcase
      drive_beat($sformatf("%s_beat%0d", tag, b));
      if (pulse) pulse_in_valid($sformatf("%s_beat%0d", tag, b));
    end
    wait_out(tag);
    check_result(tag);
    handshake(tag);
  endtask

  initial begin
    int n;
    logic [ACC_W*OUT_W-1:0] held;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    image     = '0;
    filter    = '0;
    model_clear();
    @(negedge clk);
    do_reset("reset");

    // Basic: in_valid held high, measure latency to out_valid.
    set_basic(1'b0);
    image    = pack_img();
    filter   = pack_flt();
    for (int b = 0; b < CH; b++) model_add();
    in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("basic_calc_in_ready", 64'(in_ready), 64'd0);
      if (n == 5) chk("basic_between_in_ready", 64'(in_ready), 64'd1);
      if (n == 5) chk("basic_between_busy", 64'(busy), 64'd1);
    end
    in_valid = 1'b0;
    chk("basic_latency", 64'(n), 64'd15);
    check_result("basic");

    // Backpressure: hold result for 10 cycles, in_valid ignored in OUT.
    held = conv_out;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      @(negedge clk);
      chk($sformatf("bp%0d_out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("bp%0d_in_ready", i), 64'(in_ready), 64'd0);
      chk($sformatf("bp%0d_conv_out", i), 64'(conv_out), 64'(held));
    end
    in_valid = 1'b0;
    $display("backpressure: held conv_out for 10 cycles");
    handshake("basic");

    run_group("fresh_after_bp", 0, 1'b0);
    run_group("per_ch_filters", 1, 1'b0);
    run_group("random_a", 2, 1'b1);
    run_group("random_b", 2, 1'b0);
    run_group("overflow", 3, 1'b0);

    // Reset in cycle 3 of channel 2's CALC.
    set_basic(1'b0);
    drive_beat("rst_mid_beat0");
    drive_beat("rst_mid_beat1");
    @(negedge clk);
    @(negedge clk);
    do_reset("reset_mid_calc");
    run_group("after_reset", 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
